// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and types for the demultiplexer datapath
package demux_pkg;

    localparam int NCH        = 4;
    localparam int DATA_WIDTH = 8;

    typedef logic [1:0] chan_t;

    typedef enum logic {
        MODE_ROUND_ROBIN = 1'b0,
        MODE_ADDRESSED   = 1'b1
    } dispatch_mode_t;

    function automatic chan_t next_chan(input chan_t c);
        return c + 2'd1;
    endfunction

endpackage

// File: rtl/demux4_dispatch_if.sv
// rtl/demux4_dispatch_if.sv - input handshake, four output channels and status of the dispatcher
interface demux4_dispatch_if
    import demux_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int CNTW  = 16
);

    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic                   in_mode;
    chan_t                  in_dest;
    logic [NCH-1:0]         out_valid;
    logic [NCH-1:0]         out_ready;
    logic [NCH*WIDTH-1:0]   out_data;
    chan_t                  rr_ptr;
    logic [CNTW-1:0]        accept_cnt;

    modport master (
        output in_valid,
        output in_data,
        output in_mode,
        output in_dest,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  rr_ptr,
        input  accept_cnt
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_mode,
        input  in_dest,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output rr_ptr,
        output accept_cnt
    );

endinterface

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry output slot whose data register is zero whenever it is empty
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] load_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // A load in the same cycle as a drain wins, so the slot never bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (drain) begin
            valid <= 1'b0;
            data  <= '0;
        end
    end

endmodule

// File: rtl/demux4_dispatch.sv
// rtl/demux4_dispatch.sv - registered 1-to-4 dispatcher, round-robin or addressed
module demux4_dispatch
    import demux_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int CNTW  = 16
) (
    input  logic               clk,
    input  logic               rst,
    demux4_dispatch_if.slave   bus
);

    chan_t                  tgt;
    logic                   ready;
    logic                   xfer;
    logic [NCH-1:0]         load;
    logic [NCH-1:0]         drain;
    logic [NCH-1:0]         slot_valid;
    logic [NCH*WIDTH-1:0]   slot_data;
    chan_t                  rr_q;
    logic [CNTW-1:0]        cnt_q;

    always_comb begin
        tgt = (bus.in_mode == MODE_ADDRESSED) ? bus.in_dest : rr_q;
    end

    // Readiness depends only on the targeted slot; other full channels do not stall.
    assign ready = !slot_valid[tgt] || bus.out_ready[tgt];
    assign xfer  = bus.in_valid && ready;

    genvar k;
    generate
        for (k = 0; k < NCH; k++) begin : g_slot
            assign load[k]  = xfer && (tgt == chan_t'(k));
            assign drain[k] = slot_valid[k] && bus.out_ready[k];

            demux_slot #(
                .WIDTH (WIDTH)
            ) u_slot (
                .clk       (clk),
                .rst       (rst),
                .load      (load[k]),
                .drain     (drain[k]),
                .load_data (bus.in_data),
                .valid     (slot_valid[k]),
                .data      (slot_data[k*WIDTH +: WIDTH])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q  <= '0;
            cnt_q <= '0;
        end else if (xfer) begin
            cnt_q <= cnt_q + CNTW'(1);
            if (bus.in_mode == MODE_ROUND_ROBIN) begin
                rr_q <= next_chan(rr_q);
            end
        end
    end

    assign bus.in_ready   = ready;
    assign bus.out_valid  = slot_valid;
    assign bus.out_data   = slot_data;
    assign bus.rr_ptr     = rr_q;
    assign bus.accept_cnt = cnt_q;

endmodule

// File: tb/tb_demux4_dispatch.sv
// tb/tb_demux4_dispatch.sv - self-checking bench for demux4_dispatch
module tb_demux4_dispatch;
    import demux_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    demux4_dispatch_if #(.WIDTH(8), .CNTW(16)) bus ();
    demux4_dispatch_if #(.WIDTH(8), .CNTW(4))  bus_w ();

    demux4_dispatch #(.WIDTH(8), .CNTW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    demux4_dispatch #(.WIDTH(8), .CNTW(4)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bus_w.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: four slots as plain arrays, pointer and counter as integers.
    logic       m_valid [4];
    logic [7:0] m_data  [4];
    int         m_rr;
    int         m_cnt;
    logic       exp_ready;
    logic       obs_ready;

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_valid[k] = 1'b0;
            m_data[k]  = 8'h00;
        end
        m_rr  = 0;
        m_cnt = 0;
    endtask

    function automatic logic [31:0] exp_data();
        logic [31:0] d;
        d = '0;
        for (int k = 0; k < 4; k++) d[k*8 +: 8] = m_data[k];
        return d;
    endfunction

    function automatic logic [3:0] exp_valid();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = m_valid[k];
        return v;
    endfunction

    // Drive one cycle from just after a falling edge, advance the model, return after the next falling edge.
    task automatic drive(input logic v, input logic [7:0] d, input logic mode,
                         input logic [1:0] dest, input logic [3:0] rdy);
        int t;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_mode   = mode;
        bus.in_dest   = dest;
        bus.out_ready = rdy;
        #1;
        t         = mode ? int'(dest) : m_rr;
        exp_ready = !m_valid[t] || rdy[t];
        obs_ready = bus.in_ready;
        for (int k = 0; k < 4; k++) begin
            if (m_valid[k] && rdy[k]) begin
                m_valid[k] = 1'b0;
                m_data[k]  = 8'h00;
            end
        end
        if (v && exp_ready) begin
            m_valid[t] = 1'b1;
            m_data[t]  = d;
            m_cnt      = (m_cnt + 1) % 65536;
            if (!mode) m_rr = (m_rr + 1) % 4;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++; if (bus.out_valid !== 4'h0) begin failures++; $display("FAIL reset_out_valid got=%h want=0", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h want=0", bus.out_data); end
        checks++; if (bus.rr_ptr !== 2'd0) begin failures++; $display("FAIL reset_rr_ptr got=%0d want=0", bus.rr_ptr); end
        checks++; if (bus.accept_cnt !== 16'd0) begin failures++; $display("FAIL reset_accept_cnt got=%0d want=0", bus.accept_cnt); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    endtask

    task automatic test_round_robin();
        logic [7:0] words [5];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44; words[4] = 8'h55;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, words[i], 1'b0, 2'd0, 4'hf);
            checks++; if (obs_ready !== 1'b1) begin failures++; $display("FAIL rr_in_ready[%0d] got=%b want=1", i, obs_ready); end
            checks++; if (bus.out_valid !== 4'(1 << (i % 4))) begin failures++; $display("FAIL rr_out_valid[%0d] got=%b want=%b", i, bus.out_valid, 4'(1 << (i % 4))); end
            checks++; if (bus.out_data !== (32'(words[i]) << (8 * (i % 4)))) begin failures++; $display("FAIL rr_out_data[%0d] got=%h want=%h", i, bus.out_data, 32'(words[i]) << (8 * (i % 4))); end
        end
        checks++; if (bus.rr_ptr !== 2'd1) begin failures++; $display("FAIL rr_final_ptr got=%0d want=1", bus.rr_ptr); end
        checks++; if (bus.accept_cnt !== 16'd5) begin failures++; $display("FAIL rr_accept_cnt got=%0d want=5", bus.accept_cnt); end
    endtask

    task automatic test_addressed();
        drive(1'b0, 8'h00, 1'b0, 2'd0, 4'hf);
        checks++; if (bus.out_valid !== 4'h0) begin failures++; $display("FAIL addr_drained got=%b want=0000", bus.out_valid); end
        drive(1'b1, 8'hA5, 1'b1, 2'd2, 4'h0);
        checks++; if (obs_ready !== 1'b1) begin failures++; $display("FAIL addr_first_ready got=%b want=1", obs_ready); end
        drive(1'b1, 8'h5A, 1'b1, 2'd2, 4'h0);
        checks++; if (obs_ready !== 1'b0) begin failures++; $display("FAIL addr_second_ready got=%b want=0", obs_ready); end
        checks++; if (bus.out_data !== 32'h00A5_0000) begin failures++; $display("FAIL addr_out_data got=%h want=00a50000", bus.out_data); end
        checks++; if (bus.out_valid !== 4'b0100) begin failures++; $display("FAIL addr_out_valid got=%b want=0100", bus.out_valid); end
        checks++; if (bus.rr_ptr !== 2'd1) begin failures++; $display("FAIL addr_rr_ptr got=%0d want=1", bus.rr_ptr); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 8'h3C, 1'b1, 2'd2, 4'b0100);
        checks++; if (obs_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready got=%b want=1", obs_ready); end
        checks++; if (bus.out_valid !== 4'b0100) begin failures++; $display("FAIL b2b_out_valid got=%b want=0100", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h003C_0000) begin failures++; $display("FAIL b2b_out_data got=%h want=003c0000", bus.out_data); end
    endtask

    task automatic test_rr_stall();
        drive(1'b1, 8'h77, 1'b1, 2'd1, 4'h0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 8'h99, 1'b0, 2'd0, 4'h0);
            checks++; if (obs_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready[%0d] got=%b want=0", i, obs_ready); end
            checks++; if (bus.rr_ptr !== 2'd1) begin failures++; $display("FAIL stall_rr_ptr[%0d] got=%0d want=1", i, bus.rr_ptr); end
            checks++; if (bus.out_data[15:8] !== 8'h77) begin failures++; $display("FAIL stall_ch1_data[%0d] got=%h want=77", i, bus.out_data[15:8]); end
        end
        drive(1'b1, 8'h99, 1'b0, 2'd0, 4'b0010);
        checks++; if (obs_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b want=1", obs_ready); end
        checks++; if (bus.rr_ptr !== 2'd2) begin failures++; $display("FAIL release_rr_ptr got=%0d want=2", bus.rr_ptr); end
        checks++; if (bus.out_valid !== 4'b0110) begin failures++; $display("FAIL release_out_valid got=%b want=0110", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h003C_9900) begin failures++; $display("FAIL release_out_data got=%h want=003c9900", bus.out_data); end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 8'hC0, 1'b1, 2'd0, 4'h0);
        drive(1'b1, 8'hD3, 1'b1, 2'd3, 4'h0);
        checks++; if (bus.out_valid !== 4'hf) begin failures++; $display("FAIL areset_prefill got=%b want=1111", bus.out_valid); end
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 4'h0) begin failures++; $display("FAIL areset_out_valid got=%b want=0000", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h0) begin failures++; $display("FAIL areset_out_data got=%h want=0", bus.out_data); end
        checks++; if (bus.rr_ptr !== 2'd0) begin failures++; $display("FAIL areset_rr_ptr got=%0d want=0", bus.rr_ptr); end
        checks++; if (bus.accept_cnt !== 16'd0) begin failures++; $display("FAIL areset_accept_cnt got=%0d want=0", bus.accept_cnt); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 4'($urandom));
            checks++; if (obs_ready !== exp_ready) begin failures++; $display("FAIL rand_in_ready[%0d] got=%b want=%b", i, obs_ready, exp_ready); end
            checks++; if (bus.out_valid !== exp_valid()) begin failures++; $display("FAIL rand_out_valid[%0d] got=%b want=%b", i, bus.out_valid, exp_valid()); end
            checks++; if (bus.out_data !== exp_data()) begin failures++; $display("FAIL rand_out_data[%0d] got=%h want=%h", i, bus.out_data, exp_data()); end
            checks++; if (bus.rr_ptr !== 2'(m_rr)) begin failures++; $display("FAIL rand_rr_ptr[%0d] got=%0d want=%0d", i, bus.rr_ptr, m_rr); end
            checks++; if (bus.accept_cnt !== 16'(m_cnt)) begin failures++; $display("FAIL rand_accept_cnt[%0d] got=%0d want=%0d", i, bus.accept_cnt, m_cnt); end
        end
    endtask

    task automatic test_wrap();
        bus_w.out_ready = 4'hf;
        bus_w.in_mode   = 1'b0;
        for (int i = 0; i < 17; i++) begin
            bus_w.in_valid = 1'b1;
            bus_w.in_data  = 8'(i);
            @(negedge clk);
        end
        bus_w.in_valid = 1'b0;
        checks++; if (bus_w.accept_cnt !== 4'd1) begin failures++; $display("FAIL wrap_accept_cnt got=%0d want=1", bus_w.accept_cnt); end
        checks++; if (bus_w.rr_ptr !== 2'd1) begin failures++; $display("FAIL wrap_rr_ptr got=%0d want=1", bus_w.rr_ptr); end
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.in_mode     = 1'b0;
        bus.in_dest     = '0;
        bus.out_ready   = '0;
        bus_w.in_valid  = 1'b0;
        bus_w.in_data   = '0;
        bus_w.in_mode   = 1'b0;
        bus_w.in_dest   = '0;
        bus_w.out_ready = '0;
        model_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        test_round_robin();
        test_addressed();
        test_back_to_back();
        test_rr_stall();
        test_async_reset();
        test_random();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux4_dispatch.md
# demux4_dispatch

Registered 1-to-4 dispatcher feeding the four per-channel consumers in the demultiplexer datapath. It accepts one data word per handshake on a single input port. It routes each word to one of four output channels, either round-robin or by explicit destination. Each channel holds its word in a one-entry output slot until the consumer takes it. Outputs that carry no data read as zero, matching the combinational demux convention.

## Interface
- WIDTH, 8: data word width in bits (≥1).
- CNTW, 16: width of the accepted-word counter.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  dispatcher can take the word this cycle.
- in_data  input  WIDTH  input word.
- in_mode  input  1  0 = round-robin, 1 = addressed.
- in_dest  input  2  destination channel; used only when in_mode=1.
- out_valid  output  4  bit k: channel k slot full.
- out_ready  input  4  bit k: consumer k takes the word this cycle.
- out_data  output  4*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]; reads 0 while its slot is empty.
- rr_ptr  output  2  next round-robin channel.
- accept_cnt  output  CNTW  total input words accepted; wraps modulo 2^CNTW.

## Operation
- Target channel t = in_mode ? in_dest : rr_ptr. The target is evaluated combinationally each cycle.
- in_ready = !out_valid[t] || out_ready[t]. The slot accepts when it is empty or being drained this same cycle.
- Input transfer occurs when in_valid && in_ready. On transfer:
  - slot[t] loads in_data and out_valid[t] stays or becomes 1.
  - accept_cnt increments.
  - if in_mode=0, rr_ptr advances 0→1→2→3→0.
- in_mode=1 transfers never move rr_ptr.
- Output drain of channel k occurs when out_valid[k] && out_ready[k]. On drain, slot k clears to empty and out_data[k] reads 0, unless the same channel is reloaded in that cycle.
- Simultaneous drain and load on the same channel: the slot takes the new word, out_valid[k] stays 1 and there is no bubble.
- Channels are independent. A full, stalled channel blocks only inputs targeting it. In round-robin mode that stall holds the input, because rr_ptr does not skip.
- in_data, in_dest and in_mode are ignored when in_valid=0.
- Reset values: out_valid=0, out_data=0, rr_ptr=0 and accept_cnt=0; in_ready is therefore 1. Asserting reset mid-stream discards every held word immediately, with no handshake completed.

## Timing
- Latency is 1 cycle: a word accepted at edge n appears on out_data/out_valid after edge n.
- in_ready is combinational from out_valid, out_ready, in_mode, in_dest and rr_ptr. There is no combinational path from in_data to any output.
- Throughput is one word per cycle when consumers keep out_ready high.
- Words on the same channel are delivered in acceptance order. There is no ordering guarantee across channels.
- The accept_cnt wrap from 2^CNTW−1 to 0 is silent.

## Structure
- Shared package demux_pkg holds:
  - NCH = 4
  - typedef chan_t = logic [1:0]
  - the default data-width constant shared with the combinational demux.
- Sub-module demux_slot, instantiated four times: a one-entry register with load, drain and valid, and zeroed data when empty.
- The top level holds target selection, the ready mux, rr_ptr and accept_cnt.

## Test plan
- Reset, then round-robin with out_ready=4'b1111 and in_data 0x11, 0x22, 0x33, 0x44, 0x55 on consecutive cycles:
  - channels 0–3 each show their word for one cycle, then 0x55 appears on channel 0.
  - rr_ptr ends at 1 and accept_cnt=5.
- Addressed mode with in_dest=2 and out_ready=0, sending 0xA5 then 0x5A:
  - 0xA5 is held on channel 2.
  - in_ready=0 for the second word.
  - out_data for channels 0, 1 and 3 stays 0.
  - rr_ptr is unchanged.
- Channel 2 full and in_dest=2, with out_ready[2]=1 in the same cycle as a new word 0x3C:
  - out_valid[2] stays 1 and the data becomes 0x3C, with no bubble cycle.
- Round-robin with rr_ptr=1, channel 1 full and out_ready[1]=0:
  - the input stalls with in_ready=0 and rr_ptr stays 1.
  - when out_ready[1] rises, the word is accepted the same cycle and rr_ptr becomes 2.
- Assert rst asynchronously mid-cycle with all four slots full:
  - out_valid=0, out_data=0, rr_ptr=0 and accept_cnt=0 immediately, without waiting for a clock edge.
- CNTW=4 with 17 accepted words:
  - accept_cnt wraps and reads 1.
